// File: rtl/apb_slave_pkg.sv
// Shared types and helpers for the APB register-file slave.
//   apb_state_e  : transfer FSM state
//   clog2_min1   : index width helper that never returns 0
//   strb_merge   : byte-lane merge of write data into an old word
// Helpers work on a fixed maximum width; callers cast in and out.
package apb_slave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } apb_state_e;

  localparam int MAX_DATA_W = 1024;
  localparam int MAX_STRB_W = MAX_DATA_W / 8;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [MAX_DATA_W-1:0] strb_merge(
    input logic [MAX_DATA_W-1:0] old_v,
    input logic [MAX_DATA_W-1:0] wdata,
    input logic [MAX_STRB_W-1:0] strb
  );
    logic [MAX_DATA_W-1:0] r;
    r = old_v;
    for (int b = 0; b < MAX_STRB_W; b++)
      if (strb[b]) r[b*8 +: 8] = wdata[b*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/apb_regfile_slave_decode.sv
// Combinational address decode for the APB register file.
//   addr  : byte address being decoded
//   write : access direction (writes to read-only entries are errors)
//   idx   : word index relative to BASE_ADDR (valid only when err=0)
//   err   : below base, beyond last register, misaligned, or RO write
module apb_addr_decode
  import apb_slave_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                NUM_REGS  = 8,
  parameter int                IDX_W     = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'hA000),
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
)(
  input  logic [ADDR_W-1:0] addr,
  input  logic              write,
  output logic [IDX_W-1:0]  idx,
  output logic              err
);

  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] word;
  logic              hit;
  logic              ro;

  always_comb begin
    off  = addr - BASE_ADDR;
    word = off >> 2;
    idx  = word[IDX_W-1:0];
    hit  = 1'b0;
    ro   = 1'b0;
    // Compare the full-width word index so addresses far past the
    // register block cannot alias onto a low index.
    for (int i = 0; i < NUM_REGS; i++) begin
      if (word == ADDR_W'(i)) begin
        hit = 1'b1;
        ro  = RO_MASK[i];
      end
    end
    err = (addr < BASE_ADDR) || !hit || (addr[1:0] != 2'b00) || (write && ro);
  end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB4 register-file slave: NUM_REGS word registers at BASE_ADDR with
// byte-strobe writes, WAIT_STATES extra access cycles, error responses
// and per-register read-only mapping.
//   pclk, preset          : clock, async active-high reset
//   psel_i..pstrb_i       : APB request
//   prdata_o, pready_o,
//   pslverr_o             : APB response (all registered)
//   reg_q_o               : committed RW register contents (RO slots read 0)
//   ro_d_i                : hardware values returned for RO registers
//   wr_pulse_o            : one-cycle pulse per successful register write
module apb_regfile_slave
  import apb_slave_pkg::*;
#(
  parameter int                  ADDR_W      = 32,
  parameter int                  DATA_W      = 32,
  parameter int                  NUM_REGS    = 8,
  parameter logic [ADDR_W-1:0]   BASE_ADDR   = ADDR_W'(32'hA000),
  parameter int                  WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
)(
  input  logic                         pclk,
  input  logic                         preset,
  input  logic                         psel_i,
  input  logic                         penable_i,
  input  logic [ADDR_W-1:0]            paddr_i,
  input  logic                         pwrite_i,
  input  logic [DATA_W-1:0]            pwdata_i,
  input  logic [DATA_W/8-1:0]          pstrb_i,
  output logic [DATA_W-1:0]            prdata_o,
  output logic                         pready_o,
  output logic                         pslverr_o,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q_o,
  input  logic [NUM_REGS*DATA_W-1:0]   ro_d_i,
  output logic [NUM_REGS-1:0]          wr_pulse_o
);

  localparam int         STRB_W = DATA_W / 8;
  localparam int         IDX_W  = clog2_min1(NUM_REGS);
  localparam logic [3:0] WS     = 4'(WAIT_STATES);

  apb_state_e                    state;
  logic [ADDR_W-1:0]             addr_q;
  logic                          write_q;
  logic [DATA_W-1:0]             wdata_q;
  logic [STRB_W-1:0]             strb_q;
  logic [3:0]                    cnt;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  logic              setup;
  logic              resp_enter;
  logic              commit;
  logic [ADDR_W-1:0] dec_addr;
  logic              dec_write;
  logic [IDX_W-1:0]  idx;
  logic              err;
  logic [DATA_W-1:0] rd_word;

  assign setup = (state == IDLE) && psel_i && !penable_i;

  // With zero wait states the response is loaded on the same edge that
  // latches the request, so decode the live bus while idle.
  assign dec_addr  = (state == IDLE) ? paddr_i  : addr_q;
  assign dec_write = (state == IDLE) ? pwrite_i : write_q;

  apb_addr_decode #(
    .ADDR_W    (ADDR_W),
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (IDX_W),
    .BASE_ADDR (BASE_ADDR),
    .RO_MASK   (RO_MASK)
  ) u_dec (
    .addr  (dec_addr),
    .write (dec_write),
    .idx   (idx),
    .err   (err)
  );

  assign resp_enter = (setup && (WS == 4'd0)) ||
                      ((state == WAIT) && psel_i && (cnt == 4'd1));
  assign commit     = (state == RESP) && psel_i && write_q && !err;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (idx == IDX_W'(i))
        rd_word = RO_MASK[i] ? ro_d_i[i*DATA_W +: DATA_W] : regs[i];
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
    assign reg_q_o[g*DATA_W +: DATA_W] = RO_MASK[g] ? '0 : regs[g];
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state      <= IDLE;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
      cnt        <= '0;
      regs       <= '0;
      prdata_o   <= '0;
      pready_o   <= 1'b0;
      pslverr_o  <= 1'b0;
      wr_pulse_o <= '0;
    end else begin
      // Response outputs live for exactly the RESP cycle.
      pready_o   <= 1'b0;
      pslverr_o  <= 1'b0;
      prdata_o   <= '0;
      wr_pulse_o <= '0;
      if (resp_enter) begin
        pready_o  <= 1'b1;
        pslverr_o <= err;
        prdata_o  <= (!err && !dec_write) ? rd_word : '0;
      end
      case (state)
        IDLE: if (setup) begin
          addr_q  <= paddr_i;
          write_q <= pwrite_i;
          wdata_q <= pwdata_i;
          strb_q  <= pstrb_i;
          cnt     <= WS;
          state   <= (WS == 4'd0) ? RESP : WAIT;
        end
        WAIT: begin
          if (!psel_i)              state <= IDLE;
          else if (cnt == 4'd1)     state <= RESP;
          else                      cnt   <= cnt - 4'd1;
        end
        RESP: begin
          state <= IDLE;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (commit && (idx == IDX_W'(i))) begin
              regs[i]       <= DATA_W'(strb_merge(MAX_DATA_W'(regs[i]),
                                                  MAX_DATA_W'(wdata_q),
                                                  MAX_STRB_W'(strb_q)));
              wr_pulse_o[i] <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
